ecc_130_err_mon: RTL and testbench
==================================

Name: ecc_130_err_mon

Overview:
- Sits directly downstream of the 130-bit ECC check/fault-detect stage on the FIFO memory read path.
- Registers the corrected read word through a 2-entry skid buffer with valid/ready, tagging each word with its error status.
- Counts single-bit, double-bit and checker-fault events in saturating counters.
- Captures the address and type of the first error, and raises a level interrupt until software clears it.

Parameters:
- DATA_WIDTH, 130, width of the corrected data word.
- ADDR_WIDTH, 8, width of the FIFO memory read address tagged with each word.
- CNT_WIDTH, 16, width of each saturating error counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- in_vld  input  1  checked read word valid this cycle
- in_rdy  output  1  block can accept a word
- in_data  input  DATA_WIDTH  corrected data from the ECC check stage
- in_addr  input  ADDR_WIDTH  memory address the word was read from
- sbit_err  input  1  single-bit error corrected (qualified by in_vld)
- dbit_err  input  1  uncorrectable double-bit error (qualified by in_vld)
- ecc_fault  input  1  dual-checker mismatch (qualified by in_vld)
- out_vld  output  1  output word valid
- out_rdy  input  1  downstream accepts output word
- out_data  output  DATA_WIDTH  registered data
- out_err  output  2  error tag: 0 none, 1 sbit, 2 dbit, 3 fault
- cnt_clr  input  1  synchronous clear of all counters
- irq_clr  input  1  clear interrupt and first-error capture
- sbit_cnt  output  CNT_WIDTH  single-bit error count
- dbit_cnt  output  CNT_WIDTH  double-bit error count
- fault_cnt  output  CNT_WIDTH  checker fault count
- first_vld  output  1  first-error capture valid
- first_addr  output  ADDR_WIDTH  address of first error
- first_type  output  2  type of first error, same encoding as out_err
- irq  output  1  level interrupt

Behaviour:
- Clocking/reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values: all outputs 0, except in_rdy=1 one cycle after reset release. in_rdy=0 while rst_n=0.
- Accept: accept = in_vld & in_rdy. Error inputs are ignored when accept=0.
- Error type encoding, priority fault > dbit > sbit: type = ecc_fault ? 3 : dbit_err ? 2 : sbit_err ? 1 : 0.
- Skid buffer: 2 entries. Main register drives out_*; skid register holds one overflow word.
  - in_rdy is registered: in_rdy = ~skid_full.
  - Latency: in-to-out 1 cycle when the buffer is empty.
  - Order is preserved.
  - out_* are held stable while out_vld=1 and out_rdy=0.
- Skid behaviour by case:
  - Accept with main empty, or main draining this cycle: load main.
  - Accept with main held: load skid.
  - Main drains with skid full: skid moves to main, skid empties.
- Counters:
  - On accept with type 1/2/3, increment sbit_cnt/dbit_cnt/fault_cnt respectively; one counter per accept.
  - Saturate at 2^CNT_WIDTH-1; no wrap.
  - cnt_clr with an increment in the same cycle: that counter = 1, others = 0.
- First-error capture, state machine IDLE -> ARMED_PEND:
  - IDLE: first_vld=0, irq=0. Accept with type!=0 -> ARMED_PEND; capture first_addr=in_addr, first_type=type.
  - ARMED_PEND: first_vld=1, irq=1 (subject to the Optional Feature). Later errors only count and never overwrite the capture.
  - irq_clr in ARMED_PEND -> IDLE, first_vld/first_addr/first_type cleared.
  - irq_clr and a new error accept in the same cycle: stay ARMED_PEND with the new error captured.
  - irq_clr in IDLE: no effect.
- irq is registered, asserted the cycle after the capturing accept.
- Reset mid-operation: buffered words are discarded, counters zero, state IDLE.

Optional Feature:
- Macro ECC_130_ERR_MON_SBIT_IRQ_EN.
- Defined: any error type (1, 2, 3) captures and raises irq.
- Undefined:
  - Type 1 (sbit) only counts and tags; it never captures or raises irq.
  - Types 2 and 3 capture and raise irq.
- Counters are identical in both builds.

Test Plan:
- Reset, then 10 clean words, out_rdy=1 -> each word appears 1 cycle later with out_err=0; counters 0; irq=0.
- out_rdy=0 for 3 cycles while in_vld=1 -> main+skid fill, in_rdy=0 from the 3rd cycle. Release out_rdy -> 2 buffered words emitted in order, none lost or duplicated.
- Accept at addr 0x12 with dbit_err=1, then addr 0x34 with ecc_fault=1 -> dbit_cnt=1, fault_cnt=1, first_addr=0x12, first_type=2, irq=1 from the cycle after the first accept.
- Same cycle irq_clr=1 and accept with dbit_err=1, addr 0x55 -> first_vld=1, first_addr=0x55; irq stays 1.
- CNT_WIDTH=4, 20 sbit_err accepts -> sbit_cnt=15. Then cnt_clr=1 with a sbit accept in the same cycle -> sbit_cnt=1.
- Feature undefined, single sbit_err accept -> sbit_cnt=1, out_err=1, irq=0, first_vld=0. Feature defined -> irq=1, first_type=1.

Source files
------------

// File: rtl/ecc_130_err_mon_if.sv
// ----------------------------------------------------------------------------
// ecc_130_err_mon_if
// Bundles every non-clock, non-reset signal of ecc_130_err_mon.
//   master : the side that drives the checked read words and the software
//            controls (ECC check stage plus register block / testbench).
//   slave  : ecc_130_err_mon itself.
// Signals:
//   in_vld/in_rdy/in_data/in_addr        checked read word handshake
//   sbit_err/dbit_err/ecc_fault          error flags, qualified by in_vld
//   out_vld/out_rdy/out_data/out_err     registered, tagged output word
//   cnt_clr/irq_clr                      software clears
//   sbit_cnt/dbit_cnt/fault_cnt          saturating error counters
//   first_vld/first_addr/first_type/irq  first-error capture and interrupt
// ----------------------------------------------------------------------------
interface ecc_130_err_mon_if #(
    parameter int DATA_WIDTH = 130,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic                  in_vld;
    logic                  in_rdy;
    logic [DATA_WIDTH-1:0] in_data;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic                  sbit_err;
    logic                  dbit_err;
    logic                  ecc_fault;
    logic                  out_vld;
    logic                  out_rdy;
    logic [DATA_WIDTH-1:0] out_data;
    logic [1:0]            out_err;
    logic                  cnt_clr;
    logic                  irq_clr;
    logic [CNT_WIDTH-1:0]  sbit_cnt;
    logic [CNT_WIDTH-1:0]  dbit_cnt;
    logic [CNT_WIDTH-1:0]  fault_cnt;
    logic                  first_vld;
    logic [ADDR_WIDTH-1:0] first_addr;
    logic [1:0]            first_type;
    logic                  irq;

    modport master (
        output in_vld, in_data, in_addr, sbit_err, dbit_err, ecc_fault,
               out_rdy, cnt_clr, irq_clr,
        input  in_rdy, out_vld, out_data, out_err, sbit_cnt, dbit_cnt,
               fault_cnt, first_vld, first_addr, first_type, irq
    );

    modport slave (
        input  in_vld, in_data, in_addr, sbit_err, dbit_err, ecc_fault,
               out_rdy, cnt_clr, irq_clr,
        output in_rdy, out_vld, out_data, out_err, sbit_cnt, dbit_cnt,
               fault_cnt, first_vld, first_addr, first_type, irq
    );
endinterface

// File: rtl/ecc_130_err_mon.sv
// ----------------------------------------------------------------------------
// ecc_130_err_mon
// Error monitor behind the 130-bit ECC check stage of the FIFO read path.
// Passes the corrected word through a 2-entry skid buffer tagged with its
// error type, counts single-bit / double-bit / checker-fault events in
// saturating counters, and captures the first error (address + type) with a
// level interrupt held until software clears it.
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    ecc_130_err_mon_if.slave (all data, handshake, status and control)
//
// Build option:
//   ECC_130_ERR_MON_SBIT_IRQ_EN  when defined, single-bit errors also capture
//                                and raise irq; otherwise only double-bit and
//                                checker-fault errors do. Counters are the same
//                                in both builds.
//
// Error tag encoding: 0 none, 1 sbit, 2 dbit, 3 fault (fault > dbit > sbit).
// ----------------------------------------------------------------------------
module ecc_130_err_mon #(
    parameter int DATA_WIDTH = 130,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    ecc_130_err_mon_if.slave   bus
);

    typedef enum logic {
        ST_IDLE,
        ST_ARMED_PEND
    } state_t;

    // Priority encode the checker flags into the 2-bit tag.
    function automatic logic [1:0] f_err_type(input logic fault,
                                              input logic dbit,
                                              input logic sbit);
        if (fault)     return 2'd3;
        else if (dbit) return 2'd2;
        else if (sbit) return 2'd1;
        else           return 2'd0;
    endfunction

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] f_sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Counter next value; a clear wins over the old count but not over an
    // increment landing in the same cycle, which leaves the count at 1.
    function automatic logic [CNT_WIDTH-1:0] f_cnt_next(input logic [CNT_WIDTH-1:0] c,
                                                        input logic clr,
                                                        input logic hit);
        if (clr)      return hit ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : '0;
        else if (hit) return f_sat_inc(c);
        else          return c;
    endfunction

    logic                  r_in_rdy;
    logic                  r_main_vld;
    logic [DATA_WIDTH-1:0] r_main_data;
    logic [1:0]            r_main_err;
    logic                  r_skid_vld;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [1:0]            r_skid_err;

    logic [CNT_WIDTH-1:0]  r_sbit_cnt;
    logic [CNT_WIDTH-1:0]  r_dbit_cnt;
    logic [CNT_WIDTH-1:0]  r_fault_cnt;

    state_t                r_state;
    logic                  r_first_vld;
    logic [ADDR_WIDTH-1:0] r_first_addr;
    logic [1:0]            r_first_type;
    logic                  r_irq;

    logic                  w_accept;
    logic [1:0]            w_in_type;
    logic                  w_main_free;
    logic                  w_skid_load;
    logic                  w_skid_vld_nxt;
    logic                  w_cap_hit;

    assign w_accept  = bus.in_vld & r_in_rdy;
    assign w_in_type = f_err_type(bus.ecc_fault, bus.dbit_err, bus.sbit_err);

    // Main register can take a new word when it is empty or being drained.
    assign w_main_free = ~r_main_vld | bus.out_rdy;
    assign w_skid_load = w_accept & ~w_main_free;
    // in_rdy is only high with the skid empty, so an accept never coincides
    // with a full skid; when main frees, the skid always empties into it.
    assign w_skid_vld_nxt = w_main_free ? 1'b0 : (r_skid_vld | w_accept);

`ifdef ECC_130_ERR_MON_SBIT_IRQ_EN
    assign w_cap_hit = w_accept & (w_in_type != 2'd0);
`else
    assign w_cap_hit = w_accept & w_in_type[1];
`endif

    // ---- Skid buffer: main (output) stage and ready ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_rdy    <= 1'b0;
            r_main_vld  <= 1'b0;
            r_main_data <= '0;
            r_main_err  <= 2'd0;
            r_skid_vld  <= 1'b0;
        end else begin
            r_in_rdy   <= ~w_skid_vld_nxt;
            r_skid_vld <= w_skid_vld_nxt;
            if (w_main_free) begin
                if (r_skid_vld) begin
                    r_main_vld  <= 1'b1;
                    r_main_data <= r_skid_data;
                    r_main_err  <= r_skid_err;
                end else if (w_accept) begin
                    r_main_vld  <= 1'b1;
                    r_main_data <= bus.in_data;
                    r_main_err  <= w_in_type;
                end else begin
                    r_main_vld  <= 1'b0;
                end
            end
        end
    end

    // ---- Skid buffer: overflow data (qualified by r_skid_vld) ----
    always_ff @(posedge clk) begin
        if (w_skid_load) begin
            r_skid_data <= bus.in_data;
            r_skid_err  <= w_in_type;
        end
    end

    // ---- Error counters ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sbit_cnt  <= '0;
            r_dbit_cnt  <= '0;
            r_fault_cnt <= '0;
        end else begin
            r_sbit_cnt  <= f_cnt_next(r_sbit_cnt,  bus.cnt_clr, w_accept & (w_in_type == 2'd1));
            r_dbit_cnt  <= f_cnt_next(r_dbit_cnt,  bus.cnt_clr, w_accept & (w_in_type == 2'd2));
            r_fault_cnt <= f_cnt_next(r_fault_cnt, bus.cnt_clr, w_accept & (w_in_type == 2'd3));
        end
    end

    // ---- First-error capture FSM with registered irq ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_first_vld  <= 1'b0;
            r_first_addr <= '0;
            r_first_type <= 2'd0;
            r_irq        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cap_hit) begin
                        r_state      <= ST_ARMED_PEND;
                        r_first_vld  <= 1'b1;
                        r_first_addr <= bus.in_addr;
                        r_first_type <= w_in_type;
                        r_irq        <= 1'b1;
                    end
                end
                ST_ARMED_PEND: begin
                    // Later errors never overwrite the capture, except when the
                    // clear and a new error land together: the new one re-arms.
                    if (bus.irq_clr) begin
                        if (w_cap_hit) begin
                            r_first_addr <= bus.in_addr;
                            r_first_type <= w_in_type;
                        end else begin
                            r_state      <= ST_IDLE;
                            r_first_vld  <= 1'b0;
                            r_first_addr <= '0;
                            r_first_type <= 2'd0;
                            r_irq        <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_first_vld  <= 1'b0;
                    r_first_addr <= '0;
                    r_first_type <= 2'd0;
                    r_irq        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_rdy     = r_in_rdy;
    assign bus.out_vld    = r_main_vld;
    assign bus.out_data   = r_main_data;
    assign bus.out_err    = r_main_err;
    assign bus.sbit_cnt   = r_sbit_cnt;
    assign bus.dbit_cnt   = r_dbit_cnt;
    assign bus.fault_cnt  = r_fault_cnt;
    assign bus.first_vld  = r_first_vld;
    assign bus.first_addr = r_first_addr;
    assign bus.first_type = r_first_type;
    assign bus.irq        = r_irq;

endmodule

// File: tb/tb_ecc_130_err_mon.sv
// ----------------------------------------------------------------------------
// tb_ecc_130_err_mon
// Directed bench for ecc_130_err_mon with CNT_WIDTH=4 so that counter
// saturation is reachable in a few cycles. Expected values are hand-derived.
// Honours ECC_130_ERR_MON_SBIT_IRQ_EN for the single-bit interrupt checks.
// ----------------------------------------------------------------------------
module tb_ecc_130_err_mon;

    localparam int DW = 130;
    localparam int AW = 8;
    localparam int CW = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    ecc_130_err_mon_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) u_if ();

    ecc_130_err_mon #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input int i);
        logic [1:0]  hi;
        logic [63:0] mid;
        logic [63:0] lo;
        hi  = 2'(i);
        mid = 64'hC0DE_0000_0000_0000 | 64'(i);
        lo  = 64'hA5A5_5A5A_0000_0000 + 64'(i * 7);
        return {hi, mid, lo};
    endfunction

    // Advance one clock; outputs are read 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [DW-1:0] d, input logic [AW-1:0] a,
                         input logic s, input logic db, input logic f);
        u_if.in_vld    = vld;
        u_if.in_data   = d;
        u_if.in_addr   = a;
        u_if.sbit_err  = s;
        u_if.dbit_err  = db;
        u_if.ecc_fault = f;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        u_if.out_rdy = 1'b1;
        u_if.cnt_clr = 1'b0;
        u_if.irq_clr = 1'b0;
        tick();
        tick();
        n_tests++; if (u_if.in_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_in_rdy_low: got %0h want 0", u_if.in_rdy); end
        rst_n = 1'b1;
        tick();
        n_tests++; if (u_if.in_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_in_rdy_high: got %0h want 1", u_if.in_rdy); end
        n_tests++; if (u_if.out_vld !== 1'b0 || u_if.out_data !== '0 || u_if.out_err !== 2'd0) begin n_fail++; $display("FAIL rst_out: vld %0h data %0h err %0h want 0", u_if.out_vld, u_if.out_data, u_if.out_err); end
        n_tests++; if (u_if.sbit_cnt !== 4'd0 || u_if.dbit_cnt !== 4'd0 || u_if.fault_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_cnt: got %0h %0h %0h want 0 0 0", u_if.sbit_cnt, u_if.dbit_cnt, u_if.fault_cnt); end
        n_tests++; if (u_if.irq !== 1'b0 || u_if.first_vld !== 1'b0 || u_if.first_addr !== 8'h00 || u_if.first_type !== 2'd0) begin n_fail++; $display("FAIL rst_first: irq %0h vld %0h addr %0h type %0h want 0", u_if.irq, u_if.first_vld, u_if.first_addr, u_if.first_type); end
    endtask

    task automatic test_clean_stream();
        u_if.out_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, mk(i), 8'(i), 1'b0, 1'b0, 1'b0);
            tick();
            n_tests++; if (u_if.out_vld !== 1'b1 || u_if.out_data !== mk(i) || u_if.out_err !== 2'd0) begin n_fail++; $display("FAIL clean_word%0d: vld %0h data %0h err %0h want 1 %0h 0", i, u_if.out_vld, u_if.out_data, u_if.out_err, mk(i)); end
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        n_tests++; if (u_if.out_vld !== 1'b0) begin n_fail++; $display("FAIL clean_drain: out_vld %0h want 0", u_if.out_vld); end
        n_tests++; if (u_if.sbit_cnt !== 4'd0 || u_if.dbit_cnt !== 4'd0 || u_if.fault_cnt !== 4'd0 || u_if.irq !== 1'b0) begin n_fail++; $display("FAIL clean_status: cnt %0h %0h %0h irq %0h want 0", u_if.sbit_cnt, u_if.dbit_cnt, u_if.fault_cnt, u_if.irq); end
    endtask

    task automatic test_back_pressure();
        u_if.out_rdy = 1'b0;
        drive(1'b1, mk(20), 8'h20, 1'b0, 1'b0, 1'b0);
        tick();
        n_tests++; if (u_if.out_data !== mk(20) || u_if.out_vld !== 1'b1 || u_if.in_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_first: data %0h vld %0h rdy %0h want %0h 1 1", u_if.out_data, u_if.out_vld, u_if.in_rdy, mk(20)); end
        drive(1'b1, mk(21), 8'h21, 1'b0, 1'b0, 1'b0);
        tick();
        n_tests++; if (u_if.in_rdy !== 1'b0 || u_if.out_data !== mk(20)) begin n_fail++; $display("FAIL bp_full: rdy %0h data %0h want 0 %0h", u_if.in_rdy, u_if.out_data, mk(20)); end
        drive(1'b1, mk(22), 8'h22, 1'b0, 1'b0, 1'b0);
        tick();
        n_tests++; if (u_if.in_rdy !== 1'b0 || u_if.out_data !== mk(20) || u_if.out_vld !== 1'b1) begin n_fail++; $display("FAIL bp_hold: rdy %0h data %0h vld %0h want 0 %0h 1", u_if.in_rdy, u_if.out_data, u_if.out_vld, mk(20)); end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        u_if.out_rdy = 1'b1;
        tick();
        n_tests++; if (u_if.out_vld !== 1'b1 || u_if.out_data !== mk(21) || u_if.in_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_second: vld %0h data %0h rdy %0h want 1 %0h 1", u_if.out_vld, u_if.out_data, u_if.in_rdy, mk(21)); end
        tick();
        n_tests++; if (u_if.out_vld !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: out_vld %0h want 0", u_if.out_vld); end
    endtask

    task automatic test_first_error();
        u_if.out_rdy = 1'b1;
        drive(1'b1, mk(30), 8'h12, 1'b0, 1'b1, 1'b0);
        tick();
        n_tests++; if (u_if.irq !== 1'b1 || u_if.first_vld !== 1'b1 || u_if.first_addr !== 8'h12 || u_if.first_type !== 2'd2) begin n_fail++; $display("FAIL first_capture: irq %0h vld %0h addr %0h type %0h want 1 1 12 2", u_if.irq, u_if.first_vld, u_if.first_addr, u_if.first_type); end
        n_tests++; if (u_if.out_err !== 2'd2) begin n_fail++; $display("FAIL tag_dbit: got %0h want 2", u_if.out_err); end
        drive(1'b1, mk(31), 8'h34, 1'b1, 1'b1, 1'b1);
        tick();
        n_tests++; if (u_if.out_err !== 2'd3) begin n_fail++; $display("FAIL tag_fault_prio: got %0h want 3", u_if.out_err); end
        n_tests++; if (u_if.first_addr !== 8'h12 || u_if.first_type !== 2'd2 || u_if.irq !== 1'b1) begin n_fail++; $display("FAIL first_hold: addr %0h type %0h irq %0h want 12 2 1", u_if.first_addr, u_if.first_type, u_if.irq); end
        n_tests++; if (u_if.dbit_cnt !== 4'd1 || u_if.fault_cnt !== 4'd1 || u_if.sbit_cnt !== 4'd0) begin n_fail++; $display("FAIL err_counts: s %0h d %0h f %0h want 0 1 1", u_if.sbit_cnt, u_if.dbit_cnt, u_if.fault_cnt); end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_clr_collision();
        u_if.irq_clr = 1'b1;
        drive(1'b1, mk(40), 8'h55, 1'b0, 1'b1, 1'b0);
        tick();
        n_tests++; if (u_if.first_vld !== 1'b1 || u_if.first_addr !== 8'h55 || u_if.first_type !== 2'd2 || u_if.irq !== 1'b1) begin n_fail++; $display("FAIL clr_recapture: vld %0h addr %0h type %0h irq %0h want 1 55 2 1", u_if.first_vld, u_if.first_addr, u_if.first_type, u_if.irq); end
        n_tests++; if (u_if.dbit_cnt !== 4'd2) begin n_fail++; $display("FAIL clr_dbit_cnt: got %0h want 2", u_if.dbit_cnt); end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        n_tests++; if (u_if.irq !== 1'b0 || u_if.first_vld !== 1'b0 || u_if.first_addr !== 8'h00 || u_if.first_type !== 2'd0) begin n_fail++; $display("FAIL irq_clear: irq %0h vld %0h addr %0h type %0h want 0", u_if.irq, u_if.first_vld, u_if.first_addr, u_if.first_type); end
        tick();
        u_if.irq_clr = 1'b0;
        n_tests++; if (u_if.irq !== 1'b0 || u_if.first_vld !== 1'b0) begin n_fail++; $display("FAIL clr_idle: irq %0h vld %0h want 0 0", u_if.irq, u_if.first_vld); end
    endtask

    task automatic test_saturation();
        u_if.cnt_clr = 1'b1;
        tick();
        u_if.cnt_clr = 1'b0;
        n_tests++; if (u_if.sbit_cnt !== 4'd0 || u_if.dbit_cnt !== 4'd0 || u_if.fault_cnt !== 4'd0) begin n_fail++; $display("FAIL cnt_clear: got %0h %0h %0h want 0 0 0", u_if.sbit_cnt, u_if.dbit_cnt, u_if.fault_cnt); end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, mk(50 + i), 8'(8'h60 + i), 1'b1, 1'b0, 1'b0);
            tick();
        end
        n_tests++; if (u_if.sbit_cnt !== 4'd15) begin n_fail++; $display("FAIL sbit_saturate: got %0h want f", u_if.sbit_cnt); end
        u_if.cnt_clr = 1'b1;
        drive(1'b1, mk(80), 8'h80, 1'b1, 1'b0, 1'b0);
        tick();
        u_if.cnt_clr = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        n_tests++; if (u_if.sbit_cnt !== 4'd1 || u_if.dbit_cnt !== 4'd0 || u_if.fault_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_with_inc: got %0h %0h %0h want 1 0 0", u_if.sbit_cnt, u_if.dbit_cnt, u_if.fault_cnt); end
        tick();
    endtask

    task automatic test_midop_reset_sbit();
        u_if.out_rdy = 1'b0;
        drive(1'b1, mk(90), 8'h90, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, mk(91), 8'h91, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        n_tests++; if (u_if.out_vld !== 1'b0 || u_if.in_rdy !== 1'b0 || u_if.dbit_cnt !== 4'd0 || u_if.irq !== 1'b0) begin n_fail++; $display("FAIL midop_reset: vld %0h rdy %0h dcnt %0h irq %0h want 0", u_if.out_vld, u_if.in_rdy, u_if.dbit_cnt, u_if.irq); end
        rst_n = 1'b1;
        u_if.out_rdy = 1'b1;
        tick();
        n_tests++; if (u_if.out_vld !== 1'b0 || u_if.in_rdy !== 1'b1) begin n_fail++; $display("FAIL midop_release: vld %0h rdy %0h want 0 1", u_if.out_vld, u_if.in_rdy); end
        drive(1'b1, mk(95), 8'h77, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        n_tests++; if (u_if.sbit_cnt !== 4'd1 || u_if.out_err !== 2'd1 || u_if.out_data !== mk(95)) begin n_fail++; $display("FAIL sbit_tag: cnt %0h err %0h data %0h want 1 1 %0h", u_if.sbit_cnt, u_if.out_err, u_if.out_data, mk(95)); end
`ifdef ECC_130_ERR_MON_SBIT_IRQ_EN
        n_tests++; if (u_if.irq !== 1'b1 || u_if.first_vld !== 1'b1 || u_if.first_type !== 2'd1 || u_if.first_addr !== 8'h77) begin n_fail++; $display("FAIL sbit_irq_en: irq %0h vld %0h type %0h addr %0h want 1 1 1 77", u_if.irq, u_if.first_vld, u_if.first_type, u_if.first_addr); end
`else
        n_tests++; if (u_if.irq !== 1'b0 || u_if.first_vld !== 1'b0) begin n_fail++; $display("FAIL sbit_no_irq: irq %0h vld %0h want 0 0", u_if.irq, u_if.first_vld); end
`endif
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        test_reset();
        test_clean_stream();
        test_back_pressure();
        test_first_error();
        test_clr_collision();
        test_saturation();
        test_midop_reset_sbit();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
